// File: rtl/zx_bus_bridge.sv
// -----------------------------------------------------------------------------
// zx_bus_bridge
//
// Glue between the negedge-strobe Z80 CPU wrapper and the rest of the
// Spectrum-style system. Turns Z80 memory cycles into one req/ack memory
// transaction each (holding the CPU with wait_n until the memory answers),
// implements the ULA port on even I/O addresses (border, beeper, mic,
// keyboard, tape input), and generates the frame interrupt.
//
// Parameters:
//   FRAME_LEN  clk cycles per interrupt period
//   INT_LEN    clk cycles int_n is held low at the start of each period
//   ROM_WP     1 = writes to 0x0000-0x3FFF are dropped and complete at once
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   cpu_a, cpu_do, cpu_di        CPU address, write data, read data
//   mreq_n, iorq_n, rd_n, wr_n,  CPU strobes (registered by the wrapper),
//   m1_n, rfsh_n                 all active low
//   wait_n, int_n                CPU wait and maskable interrupt, active low
//   mem_req, mem_we, mem_addr,   memory port request (level), direction,
//   mem_wdata                    address and write data
//   mem_ack, mem_rdata           one-cycle completion pulse and read data
//   kbd_matrix                   40 keys, bit 5*row+col, 0 = pressed
//   ear_in                       tape input
//   border, beeper, mic          ULA outputs
// -----------------------------------------------------------------------------
module zx_bus_bridge #(
    parameter int unsigned FRAME_LEN = 69888,
    parameter int unsigned INT_LEN   = 32,
    parameter bit          ROM_WP    = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_do,
    output logic [7:0]  cpu_di,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        rfsh_n,
    output logic        wait_n,
    output logic        int_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic [39:0] kbd_matrix,
    input  logic        ear_in,
    output logic [2:0]  border,
    output logic        beeper,
    output logic        mic
);

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        HOLD
    } state_t;

    localparam logic [16:0] CNT_LAST = 17'(FRAME_LEN - 1);
    localparam logic [16:0] INT_END  = 17'(INT_LEN);

    state_t      state;
    logic [7:0]  rdata_q;
    logic        ula_wr_q;
    logic [16:0] int_cnt;

    logic        mem_acc;
    logic        io_acc;
    logic        inta;
    logic        rom_drop;
    logic        ula_wr;
    logic [4:0]  kbd_col;

    // Bus cycle classification from the sampled strobes.
    always_comb begin
        mem_acc  = !mreq_n && rfsh_n && (!rd_n || !wr_n);
        io_acc   = !iorq_n && m1_n;
        inta     = !iorq_n && !m1_n;
        rom_drop = ROM_WP && !wr_n && (cpu_a[15:14] == 2'b00);
        ula_wr   = io_acc && !wr_n && !cpu_a[0];
    end

    // Memory cycle sequencer: one request per CPU memory cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= 8'hFF;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_acc) begin
                        if (rom_drop) begin
                            state <= HOLD;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= !wr_n;
                            mem_addr  <= cpu_a;
                            mem_wdata <= cpu_do;
                            state     <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            rdata_q <= mem_rdata;
                        end
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    // Park until the CPU ends the cycle so a long cycle
                    // never produces a second request.
                    if (mreq_n) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A dropped ROM write completes on its first cycle, so it is excluded
    // from the IDLE wait term.
    always_comb begin
        wait_n = !(mem_acc && ((state == IDLE && !rom_drop) || state == MEM_WAIT));
    end

    // Keyboard: a column reads 0 if a pressed key sits in any selected row
    // (row r selected by a low cpu_a[8+r]).
    always_comb begin
        kbd_col = '1;
        for (int unsigned r = 0; r < 8; r++) begin
            if (!cpu_a[8 + r]) begin
                kbd_col = kbd_col & kbd_matrix[5 * r +: 5];
            end
        end
    end

    always_comb begin
        cpu_di = rdata_q;
        if (inta) begin
            cpu_di = 8'hFF;
        end else if (io_acc && !rd_n) begin
            cpu_di = cpu_a[0] ? 8'hFF : {1'b1, ear_in, 1'b1, kbd_col};
        end
    end

    // ULA port write: latch only on the first sampled edge of the cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ula_wr_q <= 1'b0;
            border   <= '0;
            beeper   <= 1'b0;
            mic      <= 1'b0;
        end else begin
            ula_wr_q <= ula_wr;
            if (ula_wr && !ula_wr_q) begin
                border <= cpu_do[2:0];
                mic    <= cpu_do[3];
                beeper <= cpu_do[4];
            end
        end
    end

    // Frame interrupt: free-running counter, int_n low for the first
    // INT_LEN counts of each period.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            int_cnt <= '0;
            int_n   <= 1'b1;
        end else begin
            int_cnt <= (int_cnt == CNT_LAST) ? '0 : int_cnt + 17'd1;
            int_n   <= (int_cnt >= INT_END);
        end
    end

endmodule

// File: tb/tb_zx_bus_bridge.sv
module tb_zx_bus_bridge;

    localparam int unsigned FRAME = 100;
    localparam int unsigned ILEN  = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic [7:0]  cpu_di;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
    logic        wait_n, int_n;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [39:0] kbd_matrix;
    logic        ear_in;
    logic [2:0]  border;
    logic        beeper, mic;

    zx_bus_bridge #(
        .FRAME_LEN(FRAME),
        .INT_LEN  (ILEN),
        .ROM_WP   (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_a     (cpu_a),
        .cpu_do    (cpu_do),
        .cpu_di    (cpu_di),
        .mreq_n    (mreq_n),
        .iorq_n    (iorq_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .m1_n      (m1_n),
        .rfsh_n    (rfsh_n),
        .wait_n    (wait_n),
        .int_n     (int_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .kbd_matrix(kbd_matrix),
        .ear_in    (ear_in),
        .border    (border),
        .beeper    (beeper),
        .mic       (mic)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {K_MRD, K_MWR, K_IORD, K_IOWR, K_INTA, K_RFSH} kind_t;
    typedef struct packed {
        kind_t      kind;
        logic [7:0] data;
        logic [7:0] waits;
    } rec_t;
    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

    int tests  = 0;
    int failed = 0;

    rec_t exp_q[$];
    rec_t act_q[$];
    req_t exp_req_q[$];
    int   delay_q[$];

    logic [7:0] ref_mem   [0:65535];
    logic [7:0] mem_store [0:65535];
    logic [4:0] ula_model = '0;
    bit         resp_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference for a ULA port read, computed key by key.
    function automatic logic [7:0] ula_read(input logic [15:0] a, input logic [39:0] kbd,
                                            input logic ear);
        logic [4:0] k;
        if (a[0]) return 8'hFF;
        k = 5'h1F;
        for (int i = 0; i < 40; i++) begin
            if (!a[8 + i / 5] && !kbd[i]) k[i % 5] = 1'b0;
        end
        return {1'b1, ear, 1'b1, k};
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (resp_en && mem_req) begin
                d = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                repeat (d) @(posedge clk);
                #1;
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem_rdata = 8'($urandom);
                    mem_store[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata = mem_store[mem_addr];
                end
                @(posedge clk);
                #1;
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        req_prev;
        logic [15:0] held_addr;
        req_t        er;
        rec_t        e, a;
        req_prev  = 1'b0;
        held_addr = '0;
        forever begin
            @(negedge clk);
            if (reset_n && mem_req && !req_prev) begin
                if (exp_req_q.size() == 0) begin
                    check("unexpected_mem_req", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    er = exp_req_q.pop_front();
                    check("mem_we", 32'(mem_we), 32'(er.we));
                    check("mem_addr", 32'(mem_addr), 32'(er.addr));
                    if (er.we) check("mem_wdata", 32'(mem_wdata), 32'(er.wdata));
                end
                held_addr = mem_addr;
            end else if (mem_req && req_prev) begin
                check("mem_addr_stable", 32'(mem_addr), 32'(held_addr));
            end
            req_prev = mem_req;
            while (act_q.size() > 0 && exp_q.size() > 0) begin
                a = act_q.pop_front();
                e = exp_q.pop_front();
                check({e.kind.name(), "_waits"}, 32'(a.waits), 32'(e.waits));
                if (e.kind != K_MWR && e.kind != K_RFSH)
                    check({e.kind.name(), "_data"}, 32'(a.data), 32'(e.data));
            end
        end
    end

    // ---------------- CPU bus driver ----------------
    task automatic release_bus();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        m1_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic finish_mem(input kind_t k);
        rec_t r;
        int   w;
        bit   ok;
        w  = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wait_n) begin
                ok = 1'b1;
                break;
            end
            w++;
        end
        if (!ok) check("wait_timeout", 32'(w), 32'd0);
        r.kind  = k;
        r.data  = cpu_di;
        r.waits = 8'(w);
        act_q.push_back(r);
        @(posedge clk);
        #1 release_bus();
    endtask

    task automatic mem_read(input logic [15:0] a, input int d);
        rec_t e;
        @(posedge clk);
        #1;
        cpu_a = a; mreq_n = 1'b0; rd_n = 1'b0; m1_n = 1'($urandom_range(0, 1));
        exp_req_q.push_back({1'b0, a, 8'h00});
        delay_q.push_back(d);
        e.kind = K_MRD; e.data = ref_mem[a]; e.waits = 8'(d + 2);
        exp_q.push_back(e);
        finish_mem(K_MRD);
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [7:0] v, input int d);
        rec_t e;
        @(posedge clk);
        #1;
        cpu_a = a; cpu_do = v; mreq_n = 1'b0; wr_n = 1'b0;
        e.kind = K_MWR; e.data = 8'h00;
        if (a < 16'h4000) begin
            e.waits = 8'd0;
        end else begin
            exp_req_q.push_back({1'b1, a, v});
            delay_q.push_back(d);
            ref_mem[a] = v;
            e.waits = 8'(d + 2);
        end
        exp_q.push_back(e);
        finish_mem(K_MWR);
    endtask

    task automatic io_read(input logic [15:0] a, input logic [39:0] kbd, input logic ear);
        rec_t e, r;
        @(posedge clk);
        #1;
        kbd_matrix = kbd; ear_in = ear;
        cpu_a = a; iorq_n = 1'b0; rd_n = 1'b0;
        e.kind = K_IORD; e.data = ula_read(a, kbd, ear); e.waits = 8'd0;
        exp_q.push_back(e);
        @(negedge clk);
        r.kind = K_IORD; r.data = cpu_di; r.waits = 8'(!wait_n);
        act_q.push_back(r);
        @(posedge clk);
        #1 release_bus();
    endtask

    // Holds the OUT for three cycles and alters the data after the first
    // edge; only the first value may be latched.
    task automatic io_write(input logic [15:0] a, input logic [7:0] v);
        rec_t e, r;
        int   w;
        @(posedge clk);
        #1;
        cpu_a = a; cpu_do = v; iorq_n = 1'b0; wr_n = 1'b0;
        if (!a[0]) ula_model = {v[4], v[3], v[2:0]};
        e.kind = K_IOWR; e.data = {3'b000, ula_model}; e.waits = 8'd0;
        exp_q.push_back(e);
        w = 0;
        @(negedge clk); w += int'(!wait_n);
        @(posedge clk); #1 cpu_do = ~v;
        @(negedge clk); w += int'(!wait_n);
        @(negedge clk); w += int'(!wait_n);
        r.kind = K_IOWR; r.data = {3'b000, beeper, mic, border}; r.waits = 8'(w);
        act_q.push_back(r);
        @(posedge clk);
        #1 release_bus();
    endtask

    task automatic int_ack();
        rec_t e, r;
        @(posedge clk);
        #1;
        cpu_a = {8'($urandom), 8'($urandom) & 8'hFE}; iorq_n = 1'b0; m1_n = 1'b0;
        e.kind = K_INTA; e.data = 8'hFF; e.waits = 8'd0;
        exp_q.push_back(e);
        @(negedge clk);
        r.kind = K_INTA; r.data = cpu_di; r.waits = 8'(!wait_n);
        act_q.push_back(r);
        @(posedge clk);
        #1 release_bus();
    endtask

    task automatic refresh(input logic [15:0] a);
        rec_t e, r;
        int   w;
        @(posedge clk);
        #1;
        cpu_a = a; mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'($urandom_range(0, 1));
        e.kind = K_RFSH; e.data = 8'h00; e.waits = 8'd0;
        exp_q.push_back(e);
        w = 0;
        repeat (2) begin
            @(negedge clk);
            w += int'(!wait_n);
        end
        r.kind = K_RFSH; r.data = cpu_di; r.waits = 8'(w);
        act_q.push_back(r);
        @(posedge clk);
        #1 release_bus();
    endtask

    function automatic logic [15:0] rand_addr();
        return {2'($urandom), 10'd0, 4'($urandom)};
    endfunction

    // ---------------- interrupt timing checker ----------------
    task automatic check_int_timing();
        logic prev;
        int   low_run, last_fall, periods;
        prev = 1'b1; low_run = 0; last_fall = -1; periods = 0;
        for (int cyc = 0; cyc < 3 * int'(FRAME) + 20; cyc++) begin
            @(negedge clk);
            if (!int_n) low_run++;
            if (prev && !int_n) begin
                if (last_fall >= 0) check("int_period", 32'(cyc - last_fall), 32'(FRAME));
                last_fall = cyc;
            end
            if (!prev && int_n) begin
                check("int_low_len", 32'(low_run), 32'(ILEN));
                low_run = 0;
                periods++;
            end
            prev = int_n;
        end
        check("int_periods_seen_ge3", 32'(periods >= 3), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] v;
        cpu_a = '0; cpu_do = '0; release_bus();
        mem_ack = 1'b0; mem_rdata = '0; kbd_matrix = '1; ear_in = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            ref_mem[i]   = v;
            mem_store[i] = v;
        end
        ref_mem[16'h8000]   = 8'h5A;
        mem_store[16'h8000] = 8'h5A;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_int_n", 32'(int_n), 32'd1);
        check("rst_wait_n", 32'(wait_n), 32'd1);
        check("rst_cpu_di", 32'(cpu_di), 32'hFF);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_ula", 32'({border, beeper, mic}), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        fork
            check_int_timing();
            begin
                mem_read(16'h8000, 2);
                mem_write(16'h4000, 8'hC3, 0);
                mem_write(16'h1000, 8'h77, 0);
                io_write(16'h00FE, 8'h15);
                io_read(16'hFDFE, 40'hFF_FFFF_FFDF, 1'b1);
                io_read(16'h00FF, 40'h00_0000_0000, 1'b0);
                int_ack();
                refresh(16'h8000);
                mem_read(16'h4000, 1);
                mem_read(16'h1000, 3);
                for (int n = 0; n < 200; n++) begin
                    case ($urandom_range(0, 5))
                        0: mem_read(rand_addr(), int'($urandom_range(0, 4)));
                        1: mem_write(rand_addr(), 8'($urandom), int'($urandom_range(0, 4)));
                        2: io_read(16'($urandom),
                                   {8'($urandom), 32'($urandom)} | {8'($urandom), 32'($urandom)},
                                   1'($urandom));
                        3: io_write(16'($urandom), 8'($urandom));
                        4: int_ack();
                        default: refresh(16'($urandom));
                    endcase
                end
            end
        join

        // Reset while a read is parked in MEM_WAIT, then a stale ack.
        resp_en = 1'b0;
        @(posedge clk);
        #1;
        cpu_a = 16'h9000; mreq_n = 1'b0; rd_n = 1'b0;
        exp_req_q.push_back({1'b0, 16'h9000, 8'h00});
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("mwait_req_high", 32'(mem_req), 32'd1);
        check("mwait_wait_low", 32'(wait_n), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        release_bus();
        @(posedge clk);
        @(negedge clk);
        ula_model = '0;
        check("mrst_mem_req", 32'(mem_req), 32'd0);
        check("mrst_mem_we", 32'(mem_we), 32'd0);
        check("mrst_mem_addr", 32'(mem_addr), 32'd0);
        check("mrst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("mrst_wait_n", 32'(wait_n), 32'd1);
        check("mrst_int_n", 32'(int_n), 32'd1);
        check("mrst_cpu_di", 32'(cpu_di), 32'hFF);
        check("mrst_ula", 32'({border, beeper, mic}), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h77;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_req", 32'(mem_req), 32'd0);
        check("late_ack_cpu_di", 32'(cpu_di), 32'hFF);
        resp_en = 1'b1;
        mem_read(16'h4000, 1);
        io_write(16'h00FE, 8'h0A);
        mem_write(16'hC005, 8'h3C, 2);
        mem_read(16'hC005, 0);

        repeat (5) @(posedge clk);
        check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        failed++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
